mult_control: RTL

//   Sequencer for the 16x16 unsigned shift-add multiplier datapath. Latches operands on

---
 rtl/mult_control.sv | 112 +++++++++++
 1 files changed

// File: rtl/mult_control.sv
// mult_control -- sequencer for the 16x16 unsigned shift-add multiplier datapath.
//
// When idle, a start request latches both operands. The product register is loaded
// with {16'h0, multiplier}. For 16 iterations the block hands the product register
// and the latched multiplicand to the datapath. It enables the add from the product
// LSB and takes the datapath's next product back on every edge. It then pulses done
// for one cycle and returns to idle. The product stays visible on result until the
// next accepted start.
//
// Ports:
//   clk             in   1      rising-edge clock
//   reset           in   1      asynchronous, active-high; clears all state
//   start           in   1      multiply request (sampled only in IDLE)
//   multiplicand    in   WIDTH  operand A, added each iteration
//   multiplier      in   WIDTH  operand B, scanned LSB first
//   busy            out  1      high while the multiply iterates
//   done            out  1      one-cycle pulse, result valid
//   result          out  2*W    product register
//   dp_mult_res     out  WIDTH  latched multiplicand to the datapath
//   dp_product_in   out  2*W    current product register to the datapath
//   dp_write        out  1      datapath add-enable
//   dp_product_out  in   2*W    next product value from the datapath
module mult_control #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     dp_mult_res,
    output logic [2*WIDTH-1:0]   dp_product_in,
    output logic                 dp_write,
    input  logic [2*WIDTH-1:0]   dp_product_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     r_mcand;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_product <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand   <= multiplicand;
                        r_product <= {{WIDTH{1'b0}}, multiplier};
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_product <= dp_product_out;
                    // The counter wraps to zero on the final iteration edge, so it
                    // holds zero through DONE and IDLE.
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The add-enable follows the current product LSB. During iteration i that LSB
    // is bit i of the original multiplier.
    assign w_write       = (r_state == S_RUN) && r_product[0];

    assign busy          = r_busy;
    assign done          = r_done;
    assign result        = r_product;
    assign dp_mult_res   = r_mcand;
    assign dp_product_in = r_product;
    assign dp_write      = w_write;

endmodule
